morse_symbol_capture: RTL

MORSE_SYMBOL_CAPTURE -- requirements
Module: morse_symbol_capture

---
 rtl/morse_symbol_capture.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/morse_symbol_capture.sv
// -----------------------------------------------------------------------------
// morse_symbol_capture
//
// Turns a raw Morse key into per-character write words for a register file.
// The key is synchronised into the clk domain. Marks and spaces are timed in
// units of the external 'tick' enable. Each finished character is written out
// as one strobe on wr_en, with wr_data = {count[2:0], symbols[4:0]}. In the
// symbol field the first symbol is in bit 0, and a 1 means dash.
//
// Optional feature: define MORSE_WORD_GAP_EN to emit a word separator
// (8'hE0) once the key has stayed up for WORD_GAP ticks after the last mark.
// The default build has no word-gap logic.
//
// Parameters
//   DOT_MAX   longest mark, in ticks, that counts as a dot
//   CHAR_GAP  key-up ticks that end a character
//   WORD_GAP  key-up ticks from the last mark that end a word (macro only)
//   CNT_W     width of the tick counter
//
// Ports
//   clk        clock, all state updates on the rising edge
//   clrn       asynchronous active-low reset
//   key_in     raw key, asynchronous to clk, 1 = pressed
//   tick       timebase enable, one clk wide per time unit
//   clear_ovf  clears the sticky overflow flag
//   wr_en      one-cycle write strobe
//   wr_data    {symbol count, symbols}; held between strobes
//   busy       high whenever the capture FSM is not idle
//   overflow   sticky: a sixth or later symbol of a character was dropped
// -----------------------------------------------------------------------------
module morse_symbol_capture #(
  parameter int unsigned DOT_MAX  = 3,
  parameter int unsigned CHAR_GAP = 3,
  parameter int unsigned WORD_GAP = 7,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_in,
  input  logic       tick,
  input  logic       clear_ovf,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned LEN_W    = 3;
  localparam int unsigned SYM_W    = 5;
  localparam int unsigned MAX_SYMS = 5;
  localparam int unsigned DATA_W   = LEN_W + SYM_W;

  localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(MAX_SYMS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  DOT_LIM   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0]  CHAR_LIM  = CNT_W'(CHAR_GAP);
  localparam logic [DATA_W-1:0] WORD_SEP  = DATA_W'(8'hE0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_EMIT  = 2'd3
  } state_e;

  // Registers
  logic               key_meta_q;
  logic               key_s_q;
  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic [SYM_W-1:0]   sym_q,     sym_d;
  logic               wr_en_q,   wr_en_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               busy_q,    busy_d;
  logic               ovf_q,     ovf_d;

  // Combinational helpers
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               is_dash_c;
  logic               ovf_set_c;

`ifdef MORSE_WORD_GAP_EN
  localparam logic [CNT_W-1:0] WORD_LIM = CNT_W'(WORD_GAP);
  logic armed_q, armed_d;
`else
  // WORD_GAP only matters when the word-gap feature is built in.
  logic unused_word_gap;
  assign unused_word_gap = ^WORD_GAP;
`endif

  // Two-flop synchroniser for the asynchronous key.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
    end else begin
      key_meta_q <= key_in;
      key_s_q    <= key_meta_q;
    end
  end

  // Saturating tick counter increment and dot/dash decision.
  assign cnt_inc_c = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  assign is_dash_c = (cnt_q > DOT_LIM);

  // Next-state and output logic. A key_s change always wins over a
  // coincident tick, so every transition is decided on the pre-tick count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sym_d     = sym_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    ovf_set_c = 1'b0;
`ifdef MORSE_WORD_GAP_EN
    armed_d   = armed_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (key_s_q) begin
          state_d = S_MARK;
          cnt_d   = '0;
`ifdef MORSE_WORD_GAP_EN
          armed_d = 1'b0;
`endif
        end
`ifdef MORSE_WORD_GAP_EN
        else if (armed_q) begin
          // cnt still holds the gap counted in SPACE, so the word gap is
          // measured from the end of the last mark.
          if (cnt_q >= WORD_LIM) begin
            wr_en_d   = 1'b1;
            wr_data_d = WORD_SEP;
            armed_d   = 1'b0;
          end else if (tick) begin
            cnt_d = cnt_inc_c;
          end
        end
`endif
      end

      S_MARK: begin
        if (!key_s_q) begin
          cnt_d = '0;
          if (cnt_q == '0) begin
            // Mark shorter than one tick: a glitch, discard it.
            state_d = (len_q != '0) ? S_SPACE : S_IDLE;
          end else begin
            state_d = S_SPACE;
            if (len_q == LEN_FULL) begin
              ovf_set_c = 1'b1;
            end else begin
              sym_d = sym_q | (SYM_W'(is_dash_c) << len_q);
              len_d = len_q + LEN_W'(1);
            end
          end
        end else if (tick) begin
          cnt_d = cnt_inc_c;
        end
      end

      S_SPACE: begin
        if (key_s_q) begin
          state_d = S_MARK;
          cnt_d   = '0;
        end else if (cnt_q >= CHAR_LIM) begin
          state_d = S_EMIT;
        end else if (tick) begin
          cnt_d = cnt_inc_c;
        end
      end

      S_EMIT: begin
        wr_en_d   = 1'b1;
        wr_data_d = {len_q, sym_q};
        len_d     = '0;
        sym_d     = '0;
        state_d   = S_IDLE;
`ifdef MORSE_WORD_GAP_EN
        armed_d   = 1'b1;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new overflow in the same cycle as clear_ovf keeps the flag set.
    ovf_d  = ovf_set_c | (ovf_q & ~clear_ovf);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      sym_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sym_q     <= sym_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef MORSE_WORD_GAP_EN
  // Word-gap armed flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end
`endif

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
